hit_resolver: RTL and testbench

- Consumer of the fighter FSM outputs (state_p1/p2, char1_x/char2_x).
- Each game tick it checks attack hitboxes against the opponent and classifies contact as hit or block.
- Tracks health, drives the damage/block flags fed back into both fighter FSMs, and runs the round KO/restart FSM.
- P1 always stands left of P2 and faces right; P2 faces left.

---
 rtl/hit_resolver.sv | 198 +++++++++++++++++++
 tb/tb_hit_resolver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_resolver.sv
// hit_resolver: hitbox contact, hit/block classification, health tracking and round KO/restart FSM.
// Optional CHIP_DAMAGE_EN: a blocked attack also removes 1 health and can end the round.
module hit_resolver #(
    parameter int unsigned CHAR_WIDTH    = 128,
    parameter int unsigned ATK1_REACH    = 40,
    parameter int unsigned ATK2_REACH    = 56,
    parameter int unsigned HP_W          = 4,
    parameter int unsigned HEALTH_INIT   = 6,
    parameter int unsigned HIT_DMG       = 2,
    parameter int unsigned DAMAGE_FRAMES = 12,
    parameter int unsigned BLOCK_FRAMES  = 8,
    parameter int unsigned KO_FRAMES     = 60
) (
    input  logic            clk_game,
    input  logic            reset_n,
    input  logic [3:0]      state_p1,
    input  logic [3:0]      state_p2,
    input  logic [9:0]      char1_x,
    input  logic [9:0]      char2_x,
    input  logic            restart,
    output logic            hit_p1,
    output logic            hit_p2,
    output logic            dmg_p1,
    output logic            dmg_p2,
    output logic            blk_p1,
    output logic            blk_p2,
    output logic [HP_W-1:0] health_p1,
    output logic [HP_W-1:0] health_p2,
    output logic [1:0]      winner,
    output logic            round_active
);

    localparam int unsigned X_W  = 11;
    localparam int unsigned DC_W = $clog2(DAMAGE_FRAMES + 1);
    localparam int unsigned BC_W = $clog2(BLOCK_FRAMES + 1);
    localparam int unsigned KC_W = $clog2(KO_FRAMES + 1);

    localparam logic [3:0] ST_LEFT   = 4'd1;
    localparam logic [3:0] ST_RIGHT  = 4'd2;
    localparam logic [3:0] ST_A1_ACT = 4'd4;
    localparam logic [3:0] ST_A2_ACT = 4'd7;

    typedef enum logic [1:0] {R_FIGHT, R_KO, R_DONE} round_e;

    round_e            round_q, round_d;
    logic [KC_W-1:0]   ko_cnt_q, ko_cnt_d;
    logic [1:0]        winner_q, winner_d;
    logic [HP_W-1:0]   hp1_q, hp1_d, hp2_q, hp2_d;
    logic              hit1_q, hit1_d, hit2_q, hit2_d;
    logic [DC_W-1:0]   dcnt1_q, dcnt1_d, dcnt2_q, dcnt2_d;
    logic [BC_W-1:0]   bcnt1_q, bcnt1_d, bcnt2_q, bcnt2_d;
    logic              dmg1_q, dmg2_q, blk1_q, blk2_q;
    logic              lock1_q, lock1_d, lock2_q, lock2_d;
    logic              active_q;

    logic              act1_c, act2_c, reach1_ok_c, reach2_ok_c, conn1_c, conn2_c;
    logic [X_W-1:0]    reach1_c, reach2_c, p1_front1_c, p1_front2_c;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    // Both reach tests measure against P1's right edge plus the attacker's reach.
    assign act1_c      = (state_p1 == ST_A1_ACT) || (state_p1 == ST_A2_ACT);
    assign act2_c      = (state_p2 == ST_A1_ACT) || (state_p2 == ST_A2_ACT);
    assign reach1_c    = (state_p1 == ST_A2_ACT) ? X_W'(ATK2_REACH) : X_W'(ATK1_REACH);
    assign reach2_c    = (state_p2 == ST_A2_ACT) ? X_W'(ATK2_REACH) : X_W'(ATK1_REACH);
    assign p1_front1_c = X_W'(char1_x) + X_W'(CHAR_WIDTH) + reach1_c;
    assign p1_front2_c = X_W'(char1_x) + X_W'(CHAR_WIDTH) + reach2_c;
    assign reach1_ok_c = act1_c && (p1_front1_c >= X_W'(char2_x));
    assign reach2_ok_c = act2_c && (X_W'(char2_x) <= p1_front2_c);
    assign conn1_c     = (round_q == R_FIGHT) && reach1_ok_c && !lock1_q && !dmg2_q;
    assign conn2_c     = (round_q == R_FIGHT) && reach2_ok_c && !lock2_q && !dmg1_q;

    always_comb begin
        round_d  = round_q;
        ko_cnt_d = ko_cnt_q;
        winner_d = winner_q;
        hp1_d    = hp1_q;
        hp2_d    = hp2_q;
        hit1_d   = 1'b0;
        hit2_d   = 1'b0;
        dcnt1_d  = (dcnt1_q != '0) ? dcnt1_q - DC_W'(1) : '0;
        dcnt2_d  = (dcnt2_q != '0) ? dcnt2_q - DC_W'(1) : '0;
        bcnt1_d  = (bcnt1_q != '0) ? bcnt1_q - BC_W'(1) : '0;
        bcnt2_d  = (bcnt2_q != '0) ? bcnt2_q - BC_W'(1) : '0;
        lock1_d  = act1_c && (lock1_q || conn1_c);
        lock2_d  = act2_c && (lock2_q || conn2_c);

        // P1 attacking P2: backing away (RIGHT) blocks, anything else takes the hit.
        if (conn1_c) begin
            if (state_p2 == ST_RIGHT) begin
                bcnt2_d = BC_W'(BLOCK_FRAMES);
`ifdef CHIP_DAMAGE_EN
                hp2_d = sat_sub(hp2_d, HP_W'(1));
`endif
            end else begin
                hit1_d  = 1'b1;
                hp2_d   = sat_sub(hp2_d, HP_W'(HIT_DMG));
                dcnt2_d = DC_W'(DAMAGE_FRAMES);
                bcnt2_d = '0;
            end
        end

        if (conn2_c) begin
            if (state_p1 == ST_LEFT) begin
                bcnt1_d = BC_W'(BLOCK_FRAMES);
`ifdef CHIP_DAMAGE_EN
                hp1_d = sat_sub(hp1_d, HP_W'(1));
`endif
            end else begin
                hit2_d  = 1'b1;
                hp1_d   = sat_sub(hp1_d, HP_W'(HIT_DMG));
                dcnt1_d = DC_W'(DAMAGE_FRAMES);
                bcnt1_d = '0;
            end
        end

        case (round_q)
            R_FIGHT: begin
                if ((hp1_d == '0) || (hp2_d == '0)) begin
                    round_d  = R_KO;
                    ko_cnt_d = KC_W'(KO_FRAMES - 1);
                    winner_d = {hp1_d == '0, hp2_d == '0};
                end
            end
            R_KO: begin
                if (ko_cnt_q == '0) round_d = R_DONE;
                else                ko_cnt_d = ko_cnt_q - KC_W'(1);
            end
            R_DONE: begin
                if (restart) begin
                    round_d  = R_FIGHT;
                    hp1_d    = HP_W'(HEALTH_INIT);
                    hp2_d    = HP_W'(HEALTH_INIT);
                    winner_d = '0;
                    lock1_d  = 1'b0;
                    lock2_d  = 1'b0;
                end
            end
            default: round_d = R_FIGHT;
        endcase
    end

    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            round_q  <= R_FIGHT;
            ko_cnt_q <= '0;
            winner_q <= '0;
            hp1_q    <= HP_W'(HEALTH_INIT);
            hp2_q    <= HP_W'(HEALTH_INIT);
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            dcnt1_q  <= '0;
            dcnt2_q  <= '0;
            bcnt1_q  <= '0;
            bcnt2_q  <= '0;
            dmg1_q   <= 1'b0;
            dmg2_q   <= 1'b0;
            blk1_q   <= 1'b0;
            blk2_q   <= 1'b0;
            lock1_q  <= 1'b0;
            lock2_q  <= 1'b0;
            active_q <= 1'b1;
        end else begin
            round_q  <= round_d;
            ko_cnt_q <= ko_cnt_d;
            winner_q <= winner_d;
            hp1_q    <= hp1_d;
            hp2_q    <= hp2_d;
            hit1_q   <= hit1_d;
            hit2_q   <= hit2_d;
            dcnt1_q  <= dcnt1_d;
            dcnt2_q  <= dcnt2_d;
            bcnt1_q  <= bcnt1_d;
            bcnt2_q  <= bcnt2_d;
            dmg1_q   <= (dcnt1_d != '0);
            dmg2_q   <= (dcnt2_d != '0);
            blk1_q   <= (bcnt1_d != '0);
            blk2_q   <= (bcnt2_d != '0);
            lock1_q  <= lock1_d;
            lock2_q  <= lock2_d;
            active_q <= (round_d == R_FIGHT);
        end
    end

    assign hit_p1       = hit1_q;
    assign hit_p2       = hit2_q;
    assign dmg_p1       = dmg1_q;
    assign dmg_p2       = dmg2_q;
    assign blk_p1       = blk1_q;
    assign blk_p2       = blk2_q;
    assign health_p1    = hp1_q;
    assign health_p2    = hp2_q;
    assign winner       = winner_q;
    assign round_active = active_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Bench for hit_resolver: time-stamped behavioural model checked every cycle plus directed literal checks.
// Honours CHIP_DAMAGE_EN the same way the design does.
module tb_hit_resolver;

    localparam int CHAR_W = 128;
    localparam int REACH1 = 40;
    localparam int REACH2 = 56;
    localparam int HP0    = 6;
    localparam int DMG    = 2;
    localparam int DMG_F  = 12;
    localparam int BLK_F  = 8;
    localparam int KO_F   = 60;
`ifdef CHIP_DAMAGE_EN
    localparam int CHIP   = 1;
`else
    localparam int CHIP   = 0;
`endif

    logic       clk_game = 1'b0;
    logic       reset_n  = 1'b0;
    logic [3:0] state_p1 = 4'd0;
    logic [3:0] state_p2 = 4'd0;
    logic [9:0] char1_x  = 10'd300;
    logic [9:0] char2_x  = 10'd460;
    logic       restart  = 1'b0;
    logic       hit_p1, hit_p2, dmg_p1, dmg_p2, blk_p1, blk_p2, round_active;
    logic [3:0] health_p1, health_p2;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    hit_resolver dut (
        .clk_game(clk_game), .reset_n(reset_n),
        .state_p1(state_p1), .state_p2(state_p2),
        .char1_x(char1_x), .char2_x(char2_x), .restart(restart),
        .hit_p1(hit_p1), .hit_p2(hit_p2), .dmg_p1(dmg_p1), .dmg_p2(dmg_p2),
        .blk_p1(blk_p1), .blk_p2(blk_p2),
        .health_p1(health_p1), .health_p2(health_p2),
        .winner(winner), .round_active(round_active)
    );

    always #5 clk_game = ~clk_game;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tick count plus the tick at which each stun ends; a round is fighting, or KO until KO_F ticks pass.
    int m_t = 0, m_hp1 = HP0, m_hp2 = HP0, m_winner = 0, m_ko_edge = 0;
    int m_dmg_end1 = 0, m_dmg_end2 = 0, m_blk_end1 = 0, m_blk_end2 = 0;
    int m_hit_at1 = -1, m_hit_at2 = -1;
    bit m_used1 = 0, m_used2 = 0, m_fight = 1;

    function automatic void model_reset();
        m_t = 0; m_hp1 = HP0; m_hp2 = HP0; m_winner = 0; m_ko_edge = 0;
        m_dmg_end1 = 0; m_dmg_end2 = 0; m_blk_end1 = 0; m_blk_end2 = 0;
        m_hit_at1 = -1; m_hit_at2 = -1;
        m_used1 = 0; m_used2 = 0; m_fight = 1;
    endfunction

    function automatic void model_step();
        int  s1 = int'(state_p1);
        int  s2 = int'(state_p2);
        int  x1 = int'(char1_x);
        int  x2 = int'(char2_x);
        bit  stun1 = (m_t < m_dmg_end1);
        bit  stun2 = (m_t < m_dmg_end2);
        bit  fighting = m_fight;
        bit  done = !m_fight && (m_t - m_ko_edge >= KO_F);
        bit  a1 = (s1 == 4) || (s1 == 7);
        bit  a2 = (s2 == 4) || (s2 == 7);
        bit  c1 = fighting && a1 && (x1 + CHAR_W + (s1 == 7 ? REACH2 : REACH1) >= x2) && !m_used1 && !stun2;
        bit  c2 = fighting && a2 && (x2 <= x1 + CHAR_W + (s2 == 7 ? REACH2 : REACH1)) && !m_used2 && !stun1;
        m_t++;
        if (!a1) m_used1 = 0;
        if (!a2) m_used2 = 0;
        if (c1) begin
            m_used1 = 1;
            if (s2 == 2) begin
                m_blk_end2 = m_t + BLK_F;
                m_hp2 = (m_hp2 > CHIP) ? m_hp2 - CHIP : 0;
            end else begin
                m_hit_at1 = m_t;
                m_hp2 = (m_hp2 > DMG) ? m_hp2 - DMG : 0;
                m_dmg_end2 = m_t + DMG_F;
                m_blk_end2 = m_t;
            end
        end
        if (c2) begin
            m_used2 = 1;
            if (s1 == 1) begin
                m_blk_end1 = m_t + BLK_F;
                m_hp1 = (m_hp1 > CHIP) ? m_hp1 - CHIP : 0;
            end else begin
                m_hit_at2 = m_t;
                m_hp1 = (m_hp1 > DMG) ? m_hp1 - DMG : 0;
                m_dmg_end1 = m_t + DMG_F;
                m_blk_end1 = m_t;
            end
        end
        if (fighting && (m_hp1 == 0 || m_hp2 == 0)) begin
            m_fight = 0;
            m_ko_edge = m_t;
            m_winner = (m_hp1 == 0 ? 2 : 0) + (m_hp2 == 0 ? 1 : 0);
        end else if (done && restart) begin
            m_fight = 1; m_hp1 = HP0; m_hp2 = HP0; m_winner = 0;
            m_used1 = 0; m_used2 = 0;
        end
    endfunction

    always @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clk_game) begin
        chk("m_hit_p1",  int'(hit_p1),  (m_t == m_hit_at1) ? 1 : 0);
        chk("m_hit_p2",  int'(hit_p2),  (m_t == m_hit_at2) ? 1 : 0);
        chk("m_dmg_p1",  int'(dmg_p1),  (m_t < m_dmg_end1) ? 1 : 0);
        chk("m_dmg_p2",  int'(dmg_p2),  (m_t < m_dmg_end2) ? 1 : 0);
        chk("m_blk_p1",  int'(blk_p1),  (m_t < m_blk_end1) ? 1 : 0);
        chk("m_blk_p2",  int'(blk_p2),  (m_t < m_blk_end2) ? 1 : 0);
        chk("m_health1", int'(health_p1), m_hp1);
        chk("m_health2", int'(health_p2), m_hp2);
        chk("m_winner",  int'(winner),  m_winner);
        chk("m_active",  int'(round_active), int'(m_fight));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_game);
    endtask

    task automatic land(input bit p1_attacks);
        if (p1_attacks) state_p1 = 4'd4;
        else            state_p2 = 4'd4;
        step(1);
        state_p1 = 4'd0;
        state_p2 = 4'd0;
        step(14);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, h;
        step(2);
        reset_n = 1'b1;
        chk("rst_health1", int'(health_p1), 6);
        chk("rst_health2", int'(health_p2), 6);
        chk("rst_active",  int'(round_active), 1);
        chk("rst_winner",  int'(winner), 0);

        // Standing attack lands at gap 32: pulse, -2 health, 12 ticks of hitstun.
        state_p1 = 4'd3; step(1);
        state_p1 = 4'd4; step(1);
        chk("t1_hit", int'(hit_p1), 1);
        chk("t1_health2", int'(health_p2), 4);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            n += int'(dmg_p2);
            if (i == 1) begin
                chk("t1_pulse_once", int'(hit_p1), 0);
                state_p1 = 4'd5;
            end
            if (i == 2) state_p1 = 4'd0;
            step(1);
        end
        chk("t1_dmg_len", n, 12);

        restart = 1'b1; step(1); restart = 1'b0; step(1);
        chk("fight_restart_ignored", int'(health_p2), 4);

        // Gap 52: standing attack misses, moving attack connects.
        char2_x = 10'd480;
        state_p1 = 4'd4; step(3);
        chk("t2_a1_miss", int'(health_p2), 4);
        state_p1 = 4'd0; step(1);
        state_p1 = 4'd7; step(1);
        chk("t2_a2_hit", int'(hit_p1), 1);
        chk("t2_health2", int'(health_p2), 2);
        state_p1 = 4'd8; step(1);
        state_p1 = 4'd0; step(1);
        chk("t2_in_stun", int'(dmg_p2), 1);

        // Asynchronous reset mid-hitstun, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("ar_dmg2",    int'(dmg_p2), 0);
        chk("ar_hit1",    int'(hit_p1), 0);
        chk("ar_health1", int'(health_p1), 6);
        chk("ar_health2", int'(health_p2), 6);
        chk("ar_winner",  int'(winner), 0);
        chk("ar_active",  int'(round_active), 1);
        step(1);
        reset_n = 1'b1;
        char2_x = 10'd460;
        step(1);

        // P2 backing away blocks a 3-tick moving attack once.
        state_p2 = 4'd2;
        state_p1 = 4'd7;
        step(1);
        n = 0; h = 0;
        for (int i = 0; i < 15; i++) begin
            n += int'(blk_p2);
            h += int'(hit_p1);
            if (i == 2) state_p1 = 4'd0;
            step(1);
        end
        state_p2 = 4'd0;
        chk("t3_blk_len", n, 8);
        chk("t3_no_hit", h, 0);
        chk("t3_health2", int'(health_p2), 6 - CHIP);

        // Bring both to low health, then trade hits in the same tick.
        land(1'b1); land(1'b1);
        land(1'b0); land(1'b0);
        state_p1 = 4'd4; state_p2 = 4'd4;
        step(1);
        state_p1 = 4'd0; state_p2 = 4'd0;
        chk("t4_hit1", int'(hit_p1), 1);
        chk("t4_hit2", int'(hit_p2), 1);
        chk("t4_health1", int'(health_p1), 0);
        chk("t4_health2", int'(health_p2), 0);
        chk("t4_winner", int'(winner), 3);
        chk("t4_active", int'(round_active), 0);

        // Restart on the 60th KO tick is ignored; one tick later it is honoured.
        step(59);
        restart = 1'b1; step(1); restart = 1'b0;
        chk("ko_restart_ignored", int'(winner), 3);
        step(1);
        chk("ko_still_over", int'(winner), 3);
        chk("ko_inactive", int'(round_active), 0);
        restart = 1'b1; step(1); restart = 1'b0;
        chk("rs_health1", int'(health_p1), 6);
        chk("rs_health2", int'(health_p2), 6);
        chk("rs_winner", int'(winner), 0);
        chk("rs_active", int'(round_active), 1);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
